// File: rtl/ahb_arb_swc.sv
// N-channel AHB-Lite arbiter for the single-wait-cycle core: merges IFU, MAU and optional
// channels onto one TCM port with registered grant, locked sequences and data-phase routing.
module ahb_arb_swc #(
   parameter int unsigned N_MST    = 2,
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32,
   parameter int unsigned ARB_MODE = 0
) (
   input  logic                hclk,
   input  logic                hrstn,
   input  logic [N_MST-1:0]    m_req,
   input  logic [N_MST*AW-1:0] m_addr,
   input  logic [N_MST-1:0]    m_write,
   input  logic [N_MST*3-1:0]  m_size,
   input  logic [N_MST*DW-1:0] m_wdata,
   input  logic [N_MST-1:0]    m_lock,
   output logic [N_MST-1:0]    m_ack,
   output logic [N_MST-1:0]    m_rvalid,
   output logic [DW-1:0]       m_rdata,
   output logic [N_MST-1:0]    m_err,
   output logic [AW-1:0]       haddr,
   output logic                hwrite,
   output logic [2:0]          hsize,
   output logic [1:0]          htrans,
   output logic                hmastlock,
   output logic [DW-1:0]       hwdata,
   input  logic                hready,
   input  logic                hresp,
   input  logic [DW-1:0]       hrdata
);

   localparam int unsigned IW = (N_MST > 1) ? $clog2(N_MST) : 1;

   logic          gnt_valid;
   logic [IW-1:0] gnt_idx;
   logic [IW-1:0] rr_ptr;
   logic          d_valid;
   logic [IW-1:0] d_idx;
   logic [DW-1:0] wbuf;
   logic          err_hold;

   logic [AW-1:0] sel_addr;
   logic          sel_write;
   logic [2:0]    sel_size;
   logic [DW-1:0] sel_wdata;
   logic          sel_lock;
   logic          sel_req;
   logic          err_block;
   logic          issue;
   logic          accept;
   logic [IW-1:0] rr_next;
   logic [IW-1:0] arb_idx;
   logic          arb_found;

   always_comb begin
      sel_addr  = '0;
      sel_write = 1'b0;
      sel_size  = 3'b000;
      sel_wdata = '0;
      sel_lock  = 1'b0;
      sel_req   = 1'b0;
      for (int unsigned i = 0; i < N_MST; i++) begin
         if (gnt_idx == IW'(i)) begin
            sel_addr  = m_addr[i*AW +: AW];
            sel_write = m_write[i];
            sel_size  = m_size[i*3 +: 3];
            sel_wdata = m_wdata[i*DW +: DW];
            sel_lock  = m_lock[i];
            sel_req   = m_req[i];
         end
      end
   end

   // An error's first cycle must already suppress the next address phase.
   assign err_block = err_hold | (d_valid & hresp & ~hready);
   assign issue     = gnt_valid & sel_req & ~err_block;
   assign accept    = issue & hready;

   assign htrans    = issue ? 2'b10 : 2'b00;
   assign haddr     = gnt_valid ? sel_addr : '0;
   assign hwrite    = gnt_valid & sel_write;
   assign hsize     = gnt_valid ? sel_size : 3'b000;
   assign hmastlock = gnt_valid & sel_lock;
   assign hwdata    = wbuf;
   assign m_rdata   = hrdata;

   always_comb begin
      m_ack    = '0;
      m_rvalid = '0;
      for (int unsigned i = 0; i < N_MST; i++) begin
         m_ack[i]    = accept & (gnt_idx == IW'(i));
         m_rvalid[i] = d_valid & hready & (d_idx == IW'(i));
      end
      m_err = m_rvalid & {N_MST{hresp}};
   end

   always_comb begin
      rr_next = rr_ptr;
      if (accept) begin
         rr_next = (gnt_idx == IW'(N_MST - 1)) ? '0 : gnt_idx + IW'(1);
      end
   end

   // Round-robin search starts from the pointer as it will be after this edge.
   always_comb begin
      arb_idx   = gnt_idx;
      arb_found = 1'b0;
      for (int unsigned k = 0; k < N_MST; k++) begin
         int unsigned j;
         j = k;
         if (ARB_MODE == 1) begin
            j = 32'(rr_next) + k;
            if (j >= N_MST) begin
               j = j - N_MST;
            end
         end
         if (!arb_found && m_req[IW'(j)]) begin
            arb_found = 1'b1;
            arb_idx   = IW'(j);
         end
      end
   end

   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         gnt_valid <= 1'b0;
         gnt_idx   <= '0;
         rr_ptr    <= '0;
         d_valid   <= 1'b0;
         d_idx     <= '0;
         wbuf      <= '0;
         err_hold  <= 1'b0;
      end else if (hready) begin
         d_valid  <= accept;
         rr_ptr   <= rr_next;
         err_hold <= 1'b0;
         if (accept) begin
            d_idx <= gnt_idx;
            wbuf  <= sel_wdata;
         end
         if (!err_hold && !(gnt_valid && sel_lock && sel_req)) begin
            gnt_valid <= |m_req;
            if (|m_req) begin
               gnt_idx <= arb_idx;
            end
         end
      end else if (d_valid && hresp) begin
         err_hold <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ahb_arb_swc.sv
// Bench for ahb_arb_swc: a fixed-priority 2-channel and a round-robin 3-channel instance share
// directed stimulus and are checked every cycle against a transaction-level model.
module tb_ahb_arb_swc;

   logic        hclk;
   logic        hrstn;
   logic [2:0]  m_req;
   logic [95:0] m_addr;
   logic [2:0]  m_write;
   logic [8:0]  m_size;
   logic [95:0] m_wdata;
   logic [2:0]  m_lock;
   logic        hready;
   logic        hresp;
   logic [31:0] hrdata;

   logic [1:0]  a_ack, a_rvalid, a_err, a_htrans;
   logic [31:0] a_rdata, a_haddr, a_hwdata;
   logic        a_hwrite, a_hmastlock;
   logic [2:0]  a_hsize;

   logic [2:0]  b_ack, b_rvalid, b_err;
   logic [1:0]  b_htrans;
   logic [31:0] b_rdata, b_haddr, b_hwdata;
   logic        b_hwrite, b_hmastlock;
   logic [2:0]  b_hsize;

   int n_checks = 0;
   int n_fail   = 0;

   ahb_arb_swc #(.N_MST(2), .AW(32), .DW(32), .ARB_MODE(0)) dut_a (
      .hclk(hclk), .hrstn(hrstn),
      .m_req(m_req[1:0]), .m_addr(m_addr[63:0]), .m_write(m_write[1:0]),
      .m_size(m_size[5:0]), .m_wdata(m_wdata[63:0]), .m_lock(m_lock[1:0]),
      .m_ack(a_ack), .m_rvalid(a_rvalid), .m_rdata(a_rdata), .m_err(a_err),
      .haddr(a_haddr), .hwrite(a_hwrite), .hsize(a_hsize), .htrans(a_htrans),
      .hmastlock(a_hmastlock), .hwdata(a_hwdata),
      .hready(hready), .hresp(hresp), .hrdata(hrdata)
   );

   ahb_arb_swc #(.N_MST(3), .AW(32), .DW(32), .ARB_MODE(1)) dut_b (
      .hclk(hclk), .hrstn(hrstn),
      .m_req(m_req), .m_addr(m_addr), .m_write(m_write),
      .m_size(m_size), .m_wdata(m_wdata), .m_lock(m_lock),
      .m_ack(b_ack), .m_rvalid(b_rvalid), .m_rdata(b_rdata), .m_err(b_err),
      .haddr(b_haddr), .hwrite(b_hwrite), .hsize(b_hsize), .htrans(b_htrans),
      .hmastlock(b_hmastlock), .hwdata(b_hwdata),
      .hready(hready), .hresp(hresp), .hrdata(hrdata)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   // Model state: who owns the bus, whose data phase is open, what was buffered.
   typedef struct {
      bit          owned;
      int          owner;
      int          next_first;
      bit          pending;
      int          pend_ch;
      logic [31:0] buffered;
      bit          in_error;
   } mst_t;

   typedef struct packed {
      logic [2:0]  ack;
      logic [2:0]  rvalid;
      logic [2:0]  err;
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [1:0]  trans;
      logic        lock;
      logic [31:0] wdata;
   } out_t;

   mst_t sa, sb;

   function automatic mst_t fresh();
      mst_t s;
      s.owned = 0; s.owner = 0; s.next_first = 0;
      s.pending = 0; s.pend_ch = 0; s.buffered = '0; s.in_error = 0;
      return s;
   endfunction

   function automatic bit issues(mst_t s);
      return s.owned && m_req[s.owner] && !s.in_error && !(s.pending && hresp && !hready);
   endfunction

   function automatic int pick(int n, int mode, int first);
      for (int k = 0; k < n; k++) begin
         int c;
         c = (mode == 1) ? (first + k) % n : k;
         if (m_req[c]) return c;
      end
      return -1;
   endfunction

   function automatic out_t model_out(mst_t s);
      out_t o;
      o = '0;
      if (s.owned) begin
         o.addr = m_addr[s.owner*32 +: 32];
         o.wr   = m_write[s.owner];
         o.size = m_size[s.owner*3 +: 3];
         o.lock = m_lock[s.owner];
      end
      o.trans = issues(s) ? 2'b10 : 2'b00;
      if (issues(s) && hready) o.ack[s.owner] = 1'b1;
      if (s.pending && hready) begin
         o.rvalid[s.pend_ch] = 1'b1;
         o.err[s.pend_ch]    = hresp;
      end
      o.wdata = s.buffered;
      return o;
   endfunction

   function automatic mst_t model_next(mst_t s, int n, int mode);
      mst_t t;
      bit   acc;
      int   w;
      t = s;
      if (!hready) begin
         if (s.pending && hresp) t.in_error = 1;
         return t;
      end
      acc = issues(s);
      t.pending = acc;
      if (acc) begin
         t.pend_ch    = s.owner;
         t.buffered   = m_wdata[s.owner*32 +: 32];
         t.next_first = (s.owner + 1) % n;
      end
      if (!s.in_error && !(s.owned && m_lock[s.owner] && m_req[s.owner])) begin
         w = pick(n, mode, t.next_first);
         t.owned = (w >= 0);
         if (w >= 0) t.owner = w;
      end
      t.in_error = 0;
      return t;
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, then advance it with this cycle's inputs.
   initial begin
      out_t ea, eb;
      sa = fresh();
      sb = fresh();
      forever begin
         @(negedge hclk);
         #3;
         if (!hrstn) begin
            sa = fresh();
            sb = fresh();
         end
         ea = model_out(sa);
         eb = model_out(sb);
         cmp("a.ack", 32'(a_ack), 32'(ea.ack));
         cmp("a.rvalid", 32'(a_rvalid), 32'(ea.rvalid));
         cmp("a.err", 32'(a_err), 32'(ea.err));
         cmp("a.haddr", a_haddr, ea.addr);
         cmp("a.hwrite", 32'(a_hwrite), 32'(ea.wr));
         cmp("a.hsize", 32'(a_hsize), 32'(ea.size));
         cmp("a.htrans", 32'(a_htrans), 32'(ea.trans));
         cmp("a.hmastlock", 32'(a_hmastlock), 32'(ea.lock));
         cmp("a.hwdata", a_hwdata, ea.wdata);
         if (|ea.rvalid) cmp("a.rdata", a_rdata, hrdata);
         cmp("b.ack", 32'(b_ack), 32'(eb.ack));
         cmp("b.rvalid", 32'(b_rvalid), 32'(eb.rvalid));
         cmp("b.err", 32'(b_err), 32'(eb.err));
         cmp("b.haddr", b_haddr, eb.addr);
         cmp("b.hwrite", 32'(b_hwrite), 32'(eb.wr));
         cmp("b.hsize", 32'(b_hsize), 32'(eb.size));
         cmp("b.htrans", 32'(b_htrans), 32'(eb.trans));
         cmp("b.hmastlock", 32'(b_hmastlock), 32'(eb.lock));
         cmp("b.hwdata", b_hwdata, eb.wdata);
         if (|eb.rvalid) cmp("b.rdata", b_rdata, hrdata);
         if (hrstn) begin
            sa = model_next(sa, 2, 0);
            sb = model_next(sb, 3, 1);
         end
      end
   end

   task automatic step(input logic [2:0] req, input logic [2:0] lock, input logic rdy,
                       input logic resp);
      @(negedge hclk);
      hrstn  = 1'b1;
      m_req  = req;
      m_lock = lock;
      hready = rdy;
      hresp  = resp;
      #4;
   endtask

   task automatic do_reset();
      @(negedge hclk);
      hrstn  = 1'b0;
      m_req  = '0;
      m_lock = '0;
      hready = 1'b1;
      hresp  = 1'b0;
      #4;
   endtask

   initial begin
      hrstn   = 1'b0;
      m_req   = '0;
      m_lock  = '0;
      hready  = 1'b1;
      hresp   = 1'b0;
      hrdata  = 32'hDEADBEEF;
      m_addr  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
      m_write = 3'b010;
      m_size  = {3'd2, 3'd2, 3'd2};
      m_wdata = {32'hC3C3_C3C3, 32'h1234_5678, 32'hA0A0_A0A0};
      #3;
      cmp("rst.htrans", 32'(a_htrans), 32'd0);
      cmp("rst.haddr", a_haddr, 32'd0);
      cmp("rst.ack", 32'(b_ack), 32'd0);

      // Single read on channel 0.
      step(3'b001, 3'b000, 1'b1, 1'b0);
      cmp("rd.ack_c0", 32'(a_ack), 32'd0);
      step(3'b001, 3'b000, 1'b1, 1'b0);
      cmp("rd.ack_a", 32'(a_ack), 32'b01);
      cmp("rd.ack_b", 32'(b_ack), 32'b001);
      cmp("rd.haddr", a_haddr, 32'h100);
      step(3'b000, 3'b000, 1'b1, 1'b0);
      cmp("rd.rvalid", 32'(a_rvalid), 32'b01);
      cmp("rd.rdata", a_rdata, 32'hDEADBEEF);
      cmp("rd.err", 32'(a_err), 32'd0);
      step(3'b000, 3'b000, 1'b1, 1'b0);

      // Fixed priority: ch0 starves ch1 until it drops.
      do_reset();
      step(3'b011, 3'b000, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(3'b011, 3'b000, 1'b1, 1'b0);
         cmp("fp.ack_ch0", 32'(a_ack), 32'b01);
      end
      step(3'b010, 3'b000, 1'b1, 1'b0);
      cmp("fp.drop_ack", 32'(a_ack), 32'b00);
      step(3'b010, 3'b000, 1'b1, 1'b0);
      cmp("fp.ack_ch1", 32'(a_ack), 32'b10);
      step(3'b000, 3'b000, 1'b1, 1'b0);
      cmp("fp.hwdata", a_hwdata, 32'h1234_5678);
      cmp("fp.rvalid", 32'(a_rvalid), 32'b10);

      // Round robin across three channels, pointer wraps 2 -> 0.
      do_reset();
      step(3'b111, 3'b000, 1'b1, 1'b0);
      for (int k = 0; k < 6; k++) begin
         logic [2:0] one;
         one = 3'b001;
         step(3'b111, 3'b000, 1'b1, 1'b0);
         cmp("rr.ack_order", 32'(b_ack), 32'(one << (k % 3)));
      end
      step(3'b000, 3'b000, 1'b1, 1'b0);

      // Three wait states in ch1's data phase, with its next request pending.
      do_reset();
      step(3'b010, 3'b000, 1'b1, 1'b0);
      step(3'b010, 3'b000, 1'b1, 1'b0);
      cmp("ws.ack", 32'(a_ack), 32'b10);
      for (int k = 0; k < 3; k++) begin
         step(3'b010, 3'b000, 1'b0, 1'b0);
         cmp("ws.no_ack", 32'(a_ack), 32'd0);
         cmp("ws.no_rvalid", 32'(a_rvalid), 32'd0);
         cmp("ws.htrans", 32'(a_htrans), 32'b10);
         cmp("ws.haddr", a_haddr, 32'h200);
         cmp("ws.hwdata", a_hwdata, 32'h1234_5678);
      end
      step(3'b010, 3'b000, 1'b1, 1'b0);
      cmp("ws.rvalid", 32'(a_rvalid), 32'b10);
      step(3'b000, 3'b000, 1'b1, 1'b0);

      // Two-cycle error response on ch0's read with ch1 pending.
      do_reset();
      hrdata = 32'h0BAD_0BAD;
      step(3'b011, 3'b000, 1'b1, 1'b0);
      step(3'b011, 3'b000, 1'b1, 1'b0);
      cmp("er.ack_a", 32'(a_ack), 32'b01);
      step(3'b010, 3'b000, 1'b0, 1'b1);
      cmp("er.htrans1", 32'(b_htrans), 32'd0);
      cmp("er.ack1", 32'(b_ack), 32'd0);
      cmp("er.rvalid1", 32'(a_rvalid), 32'd0);
      step(3'b010, 3'b000, 1'b1, 1'b1);
      cmp("er.htrans2", 32'(b_htrans), 32'd0);
      cmp("er.rvalid2", 32'(a_rvalid), 32'b01);
      cmp("er.err_a", 32'(a_err), 32'b01);
      cmp("er.err_b", 32'(b_err), 32'b001);
      step(3'b010, 3'b000, 1'b1, 1'b0);
      cmp("er.ack_b_ch1", 32'(b_ack), 32'b010);
      cmp("er.err_clear", 32'(a_err), 32'd0);
      step(3'b010, 3'b000, 1'b1, 1'b0);
      cmp("er.ack_a_ch1", 32'(a_ack), 32'b10);
      step(3'b000, 3'b000, 1'b1, 1'b0);

      // Locked sequence on ch1 while ch0 requests, then reset mid data phase.
      do_reset();
      hrdata = 32'hDEADBEEF;
      step(3'b010, 3'b010, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(3'b011, 3'b010, 1'b1, 1'b0);
         cmp("lk.ack_a", 32'(a_ack), 32'b10);
         cmp("lk.ack_b", 32'(b_ack), 32'b010);
         cmp("lk.hmastlock", 32'(a_hmastlock), 32'd1);
      end
      step(3'b001, 3'b000, 1'b1, 1'b0);
      cmp("lk.release", 32'(a_hmastlock), 32'd0);
      step(3'b001, 3'b000, 1'b1, 1'b0);
      cmp("lk.ack_ch0", 32'(a_ack), 32'b01);
      @(negedge hclk);
      #1 hrstn = 1'b0;
      #3;
      cmp("mr.rvalid_a", 32'(a_rvalid), 32'd0);
      cmp("mr.rvalid_b", 32'(b_rvalid), 32'd0);
      cmp("mr.ack", 32'(a_ack), 32'd0);
      cmp("mr.htrans", 32'(a_htrans), 32'd0);
      cmp("mr.haddr", a_haddr, 32'd0);
      cmp("mr.hwdata", a_hwdata, 32'd0);
      @(negedge hclk);
      #4;
      for (int k = 0; k < 2; k++) begin
         step(3'b000, 3'b000, 1'b1, 1'b0);
         cmp("mr.no_rvalid_a", 32'(a_rvalid), 32'd0);
         cmp("mr.no_rvalid_b", 32'(b_rvalid), 32'd0);
      end
      step(3'b000, 3'b000, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
      $fatal(1);
   end

endmodule

// File: doc/ahb_arb_swc.md
Name: ahb_arb_swc

Overview:
- Parametrised N-channel AHB-Lite arbiter for the single-wait-cycle (swc) core generation.
- Merges the instruction-fetch and memory-access masters, plus optional extra channels (debug, DMA), onto one shared AHB-Lite TCM port. This replaces separate itcm/dtcm ports.
- Provides registered grant, fixed-priority or round-robin arbitration, locked sequences, write-data buffering and per-channel data-phase routing with error reporting.

Parameters:
- N_MST, 2, number of requesting channels (1..8); channel 0 is IFU, channel 1 is MAU.
- AW, 32, address width.
- DW, 32, data width.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- hclk  in  1  clock
- hrstn  in  1  asynchronous active-low reset
- m_req  in  N_MST  channel i requests an address phase; its addr/ctrl/wdata are held until m_ack[i]
- m_addr  in  N_MST*AW  per-channel address, channel i at [i*AW +: AW]
- m_write  in  N_MST  1 = write
- m_size  in  N_MST*3  per-channel hsize
- m_wdata  in  N_MST*DW  per-channel write data, valid with m_req
- m_lock  in  N_MST  keep grant after this transfer
- m_ack  out  N_MST  address phase of channel i accepted this cycle
- m_rvalid  out  N_MST  data phase of channel i completes this cycle
- m_rdata  out  DW  read data (hrdata broadcast), qualified by m_rvalid
- m_err  out  N_MST  completed data phase had hresp error
- haddr  out  AW  shared bus address
- hwrite  out  1  shared bus write
- hsize  out  3  shared bus size
- htrans  out  2  2'b00 IDLE, 2'b10 NONSEQ only
- hmastlock  out  1  m_lock of the granted channel
- hwdata  out  DW  buffered write data, driven during the data phase
- hready  in  1  slave ready
- hresp  in  1  slave error
- hrdata  in  DW  slave read data

Behaviour:
- Reset (async, hrstn=0):
  - gnt_valid=0, gnt_idx=0, rr_ptr=0, d_valid=0, d_idx=0, wbuf=0, err_hold=0.
  - Outputs: haddr=0, hwrite=0, hsize=0, htrans=IDLE, hmastlock=0, hwdata=0, m_ack=0, m_rvalid=0, m_err=0.
  - Reset mid-transfer drops all state; no ack or rvalid is issued afterwards for that transfer.
- Grant register:
  - Update only on an edge with hready=1 and err_hold=0.
  - If gnt_valid and m_lock[gnt_idx] and m_req[gnt_idx], hold the grant.
  - Otherwise gnt_idx = arb(m_req), and gnt_valid = |m_req.
  - If no request, gnt_valid=0 and gnt_idx holds (parking).
- Arbitration:
  - Mode 0: lowest set index wins.
  - Mode 1: first set index at or after rr_ptr, wrapping from N_MST-1 to 0.
  - rr_ptr = accepted_idx+1 (mod N_MST) on each accept.
- Address phase:
  - Bus signals are muxed from gnt_idx.
  - htrans=NONSEQ iff gnt_valid & m_req[gnt_idx] & ~err_hold; otherwise IDLE, with haddr/ctrl still driven from gnt_idx.
  - m_ack[i] = (i==gnt_idx) & htrans==NONSEQ & hready (combinational, single cycle).
  - Minimum latency from a new m_req rise to m_ack is 1 cycle (grant edge), then accept in the following cycle.
- Data phase:
  - On accept: d_valid<=1, d_idx<=gnt_idx, wbuf<=m_wdata[gnt_idx].
  - On an edge with hready=1 and no accept: d_valid<=0.
  - hwdata = wbuf.
  - m_rvalid[i] = d_valid & (d_idx==i) & hready.
  - m_err[i] = m_rvalid[i] & hresp.
- Back-to-back accepts pipeline, so one address phase overlaps the previous data phase.
- Wait states (hready=0): all registers hold; haddr/ctrl/htrans from the current grant stay stable.
- Error response:
  - Cycle 1 (hresp=1, hready=0): set err_hold. htrans is forced IDLE for this and the next cycle, and no new accept occurs.
  - Cycle 2 (hresp=1, hready=1): m_err[d_idx] and m_rvalid[d_idx] pulse; err_hold clears.
- Simultaneous events:
  - A channel receiving rvalid and ack in the same cycle is legal.
  - A request dropped before ack is legal and gets no ack.
  - A lock with m_req low releases the grant.
- N_MST=1: arbitration is trivial and grant follows m_req.

Test Plan:
- Single read: ch0 req addr 0x100, hready=1, hrdata=0xDEADBEEF → m_ack[0] one cycle after the grant edge; next cycle m_rvalid[0]=1, m_rdata=0xDEADBEEF, m_err=0.
- Fixed-priority contention (ARB_MODE=0): ch0 and ch1 both request continuously → only ch0 is acked. Drop ch0 → ch1 acked within 2 cycles; its write data 0x12345678 appears on hwdata in its data phase.
- Round-robin (ARB_MODE=1, N_MST=3): all three channels request continuously → ack order 0,1,2,0,1,2; rr_ptr wraps 2→0.
- Wait states: hready low for 3 cycles during ch1's data phase → haddr/htrans/hwdata stable and no ack or rvalid for those cycles; rvalid on the 4th cycle.
- Error: slave returns hresp=1/hready=0 then hresp=1/hready=1 on ch0's read → htrans IDLE for 2 cycles, m_err[0]=m_rvalid[0]=1 for one cycle, pending ch1 acked afterwards.
- Lock and reset: ch1 with m_lock=1 makes 3 transfers while ch0 requests → ch1 keeps the grant and hmastlock=1. Assert hrstn=0 mid-data-phase → all outputs reach reset values immediately, with no m_rvalid after release.
